// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   ROWS/COLS     - matrix dimensions
//   frame_res_e   - classification of one complete scan frame
//   scan_state_e  - row sequencer states
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } frame_res_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        EVAL   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key event handshake plus debounced status.
//   key_code  - {row_idx, col_idx} of the pending key event
//   key_valid - event pending, held until key_ready
//   key_ready - consumer accepts on key_valid & key_ready
//   key_down  - debounced state is one held key
//   multi_key - debounced state is two or more keys
//   overrun   - sticky, an event was dropped while one was pending
interface keypad_scanner_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_down;
    logic       multi_key;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready,
        output key_down,
        output multi_key,
        output overrun
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready,
        input  key_down,
        input  multi_key,
        input  overrun
    );

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: filters per-frame results into a committed keypad state.
//   clk, rst_n     - clock, async active-low reset
//   res_valid      - one-cycle strobe, res/res_code hold a new frame result
//   res, res_code  - frame classification and code (code meaningful for SINGLE)
//   committed      - debounced state
//   committed_code - code of the debounced SINGLE key
//   press          - strobe with res_valid on a committed NONE -> SINGLE change
//   press_code     - code belonging to press
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  frame_res_e res,
    input  logic [3:0] res_code,
    output frame_res_e committed,
    output logic [3:0] committed_code,
    output logic       press,
    output logic [3:0] press_code
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_FRAMES);

    frame_res_e       prev_res_q, prev_res_d;
    logic [3:0]       prev_code_q, prev_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    frame_res_e       committed_q, committed_d;
    logic [3:0]       committed_code_q, committed_code_d;
    logic             same;
    logic             differs;

    always_comb begin
        prev_res_d       = prev_res_q;
        prev_code_d      = prev_code_q;
        cnt_d            = cnt_q;
        committed_d      = committed_q;
        committed_code_d = committed_code_q;
        press            = 1'b0;
        press_code       = res_code;
        // Codes only distinguish results when both are SINGLE.
        same    = (res == prev_res_q) && ((res != RES_SINGLE) || (res_code == prev_code_q));
        differs = (res != committed_q) || ((res == RES_SINGLE) && (res_code != committed_code_q));
        if (res_valid) begin
            prev_res_d  = res;
            prev_code_d = res_code;
            if (same) begin
                cnt_d = (cnt_q >= DB_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_W'(1);
            end
            if ((cnt_d >= DB_MAX) && differs) begin
                committed_d      = res;
                committed_code_d = res_code;
                press            = (committed_q == RES_NONE) && (res == RES_SINGLE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_res_q       <= RES_NONE;
            prev_code_q      <= '0;
            cnt_q            <= '0;
            committed_q      <= RES_NONE;
            committed_code_q <= '0;
        end else begin
            prev_res_q       <= prev_res_d;
            prev_code_q      <= prev_code_d;
            cnt_q            <= cnt_d;
            committed_q      <= committed_d;
            committed_code_q <= committed_code_d;
        end
    end

    assign committed      = committed_q;
    assign committed_code = committed_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan controller.
//   clk, rst_n - clock, async active-low reset
//   column     - keypad columns, active-low, asynchronous to clk
//   row        - keypad rows, one-hot-low drive while a row is scanned
//   kif        - key event handshake and debounced status (master side)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int CNT_W           = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] column,
    output logic [ROWS-1:0] row,
    keypad_scanner_if.master kif
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [COLS-1:0]      col_s1_q, col_s2_q;
    scan_state_e          state_q, state_d;
    logic [1:0]           row_idx_q, row_idx_d;
    logic [CNT_W-1:0]     settle_q, settle_d;
    logic [ROWS*COLS-1:0] frame_q, frame_d;
    logic [3:0]           key_code_q, key_code_d;
    logic                 key_valid_q, key_valid_d;
    logic                 overrun_q, overrun_d;

    logic [4:0]  ones;
    logic [3:0]  hit_idx;
    frame_res_e  frame_res;
    frame_res_e  committed;
    logic [3:0]  committed_code;
    logic        press;
    logic [3:0]  press_code;
    logic        accept;

    always_comb begin
        row = '1;
        if ((state_q == DRIVE) || (state_q == SAMPLE)) begin
            row[row_idx_q] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        settle_d  = settle_q;
        frame_d   = frame_q;
        case (state_q)
            IDLE: begin
                state_d   = DRIVE;
                row_idx_d = '0;
                settle_d  = '0;
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                // Frame bit index row*COLS+col equals the key code.
                frame_d[{row_idx_q, 2'b00} +: COLS] = ~col_s2_q;
                if (row_idx_q == 2'd3) begin
                    state_d = EVAL;
                end else begin
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = DRIVE;
                end
            end
            EVAL: begin
                row_idx_d = '0;
                state_d   = DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ones    = '0;
        hit_idx = '0;
        for (int unsigned i = 0; i < ROWS * COLS; i++) begin
            if (frame_q[i]) begin
                ones    = ones + 5'd1;
                hit_idx = 4'(i);
            end
        end
        if (ones == 5'd0) begin
            frame_res = RES_NONE;
        end else if (ones == 5'd1) begin
            frame_res = RES_SINGLE;
        end else begin
            frame_res = RES_MULTI;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .res_valid     (state_q == EVAL),
        .res           (frame_res),
        .res_code      (hit_idx),
        .committed     (committed),
        .committed_code(committed_code),
        .press         (press),
        .press_code    (press_code)
    );

    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        accept      = key_valid_q & kif.key_ready;
        if (press) begin
            // An accept in the same cycle frees the slot for the new event.
            if (!key_valid_q || accept) begin
                key_code_d  = press_code;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q    <= '1;
            col_s2_q    <= '1;
            state_q     <= IDLE;
            row_idx_q   <= '0;
            settle_q    <= '0;
            frame_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            col_s1_q    <= column;
            col_s2_q    <= col_s1_q;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            settle_q    <= settle_d;
            frame_q     <= frame_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_down  = (committed == RES_SINGLE);
    assign kif.multi_key = (committed == RES_MULTI);
    assign kif.overrun   = overrun_q;

    // committed_code is exported by the debouncer for status use; the event
    // path carries its own code.
    logic unused_code;
    assign unused_code = ^committed_code;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed stimulus for keypad_scanner,
// with a frame-level reference model feeding an event scoreboard.
module tb_keypad_scanner;

    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] column;
    logic [3:0] row;
    logic [15:0] pressed = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_FRAMES(DB),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .column(column),
        .row   (row),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    // Matrix: a column reads low iff a pressed key sits in a driven row.
    always_comb begin
        column = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && pressed[r*4+c]) column[c] = 1'b0;
            end
        end
    end

    // Reference model: -1 none, 0..15 single key code, 16 multiple keys.
    int          hist[$];
    int          committed_m = -1;
    bit          pending_m = 1'b0;
    logic [3:0]  code_m = '0;
    bit          overrun_m = 1'b0;
    logic [3:0]  exp_q[$];

    function automatic int frame_result(logic [15:0] m);
        int n = $countones(m);
        if (n == 0) return -1;
        if (n > 1) return 16;
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        committed_m = -1;
        pending_m   = 1'b0;
        code_m      = '0;
        overrun_m   = 1'b0;
    endtask

    task automatic model_apply(logic [15:0] m);
        int  r = frame_result(m);
        bit  all_eq = 1'b1;
        logic [31:0] rv;
        hist.push_back(r);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB) begin
            foreach (hist[i]) if (hist[i] != r) all_eq = 1'b0;
            if (all_eq && r != committed_m) begin
                if (committed_m == -1 && r >= 0 && r < 16) begin
                    rv = r;
                    if (pending_m && !kif.key_ready) begin
                        overrun_m = 1'b1;
                    end else begin
                        exp_q.push_back(rv[3:0]);
                        pending_m = 1'b1;
                        code_m    = rv[3:0];
                    end
                end
                committed_m = r;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted handshake must match the next
    // event the model predicted.
    always @(negedge clk) begin
        if (rst_n && kif.key_valid && kif.key_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL key_event: got unexpected code %h expected no event at %0t",
                         kif.key_code, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (kif.key_code !== e) begin
                    n_fail++;
                    $display("FAIL key_event: got %h expected %h at %0t", kif.key_code, e, $time);
                end
            end
        end
    end

    // Returns at the negedge inside the end-of-frame cycle (rows idle right
    // after row 3 was driven).
    task automatic wait_eval();
        logic [3:0] prev;
        bit found = 1'b0;
        prev = row;
        for (int unsigned n = 0; n < 100; n++) begin
            @(negedge clk);
            if (prev == 4'b0111 && row == 4'b1111) begin
                found = 1'b1;
                break;
            end
            prev = row;
        end
        if (!found) check("frame_timeout", 32'd0, 32'd1);
    endtask

    // One frame: the model consumes the keys that were held for the frame
    // just evaluated, new keys are applied for the next frame, then status
    // is compared in the cycle after evaluation.
    task automatic step(logic [15:0] m);
        wait_eval();
        model_apply(pressed);
        pressed = m;
        @(negedge clk);
        check("key_down", {31'd0, kif.key_down}, {31'd0, (committed_m >= 0 && committed_m < 16)});
        check("multi_key", {31'd0, kif.multi_key}, {31'd0, (committed_m == 16)});
        check("key_valid", {31'd0, kif.key_valid}, {31'd0, pending_m});
        check("overrun", {31'd0, kif.overrun}, {31'd0, overrun_m});
        if (pending_m) check("key_code", {28'd0, kif.key_code}, {28'd0, code_m});
        if (kif.key_ready) pending_m = 1'b0;
    endtask

    task automatic hold(logic [15:0] m, int frames);
        for (int i = 0; i < frames; i++) step(m);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_row;
        logic [15:0] m;
        bit          found;
        int          j;

        kif.key_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_row", {28'd0, row}, 32'hF);
        check("reset_valid", {31'd0, kif.key_valid}, 32'd0);
        check("reset_code", {28'd0, kif.key_code}, 32'd0);
        check("reset_down", {31'd0, kif.key_down}, 32'd0);
        check("reset_overrun", {31'd0, kif.overrun}, 32'd0);
        rst_n = 1'b1;

        // Idle scan: row walk over two frames.
        wait_eval();
        model_apply(pressed);
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            j = k % 13;
            exp_row = 4'b1111;
            if (j < 12) exp_row[j/3] = 1'b0;
            check("row_walk", {28'd0, row}, {28'd0, exp_row});
            if (j == 12) model_apply(pressed);
        end
        check("idle_valid", {31'd0, kif.key_valid}, 32'd0);

        // Single press row2/col1, then release.
        m = '0; m[9] = 1'b1;
        hold(m, 4);
        hold('0, 4);

        // Bouncing row0/col3: never stable long enough.
        m = '0; m[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(m);
            step('0);
        end
        hold('0, 3);

        // Consumer stalled: second press is dropped.
        @(posedge clk); #1 kif.key_ready = 1'b0;
        m = '0; m[4] = 1'b1;
        hold(m, 4);
        hold('0, 4);
        m = '0; m[14] = 1'b1;
        hold(m, 4);
        hold('0, 4);
        check("stall_code", {28'd0, kif.key_code}, 32'h4);
        check("stall_valid", {31'd0, kif.key_valid}, 32'd1);
        check("stall_overrun", {31'd0, kif.overrun}, 32'd1);
        @(posedge clk); #1 kif.key_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_fall", {31'd0, kif.key_valid}, 32'd0);
        pending_m = 1'b0;

        // Two keys in row 0, then release one: MULTI -> SINGLE gives no event.
        m = '0; m[0] = 1'b1; m[1] = 1'b1;
        hold(m, 4);
        m[1] = 1'b0;
        hold(m, 4);
        hold('0, 4);

        // Randomized segments of 0..2 keys.
        for (int s = 0; s < 10; s++) begin
            m = '0;
            for (int t = 0; t < int'($urandom_range(0, 2)); t++) m[$urandom_range(0, 15)] = 1'b1;
            hold(m, int'($urandom_range(1, 5)));
        end
        hold('0, 4);

        // Reset in the middle of driving row 2 with a key committed and pending.
        @(posedge clk); #1 kif.key_ready = 1'b0;
        m = '0; m[6] = 1'b1;
        hold(m, 5);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (row == 4'b1011) begin
                found = 1'b1;
                break;
            end
        end
        check("row2_seen", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_row", {28'd0, row}, 32'hF);
        check("midreset_down", {31'd0, kif.key_down}, 32'd0);
        check("midreset_valid", {31'd0, kif.key_valid}, 32'd0);
        check("midreset_overrun", {31'd0, kif.overrun}, 32'd0);
        model_reset();
        pressed = '0;
        kif.key_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (row != 4'b1111) begin
                found = 1'b1;
                break;
            end
        end
        check("restart_row", {28'd0, row}, 32'hE);
        check("restart_seen", {31'd0, found}, 32'd1);
        hold('0, 2);
        m = '0; m[5] = 1'b1;
        hold(m, 4);
        hold('0, 3);

        check("events_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
